exec_stage_unit: RTL and testbench

//  Execute stage of the 5-stage ECE350 pipeline. Resolves operand bypassing from the XM and MW stages and runs the 32-bit ALU.

---
 rtl/exec_stage_unit.sv | 152 +++++++++++++++
 tb/tb_exec_stage_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_stage_unit.sv
// Execute stage: operand bypass from X/M and M/W, 32-bit ALU, branch target/compare, X/M latch.
// Optional feature macro: EXEC_BYPASS_EN (defined -> bypass network; undefined -> raw D/X operands).
module exec_stage_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] dx_ir,
  input  logic [31:0] dx_pc,
  input  logic [31:0] dx_a,
  input  logic [31:0] dx_b,
  input  logic [31:0] mw_ir,
  input  logic [31:0] mw_data,
  output logic [31:0] xm_ir,
  output logic [31:0] xm_o,
  output logic [31:0] xm_b,
  output logic        xm_ovf,
  output logic [31:0] dmem_data,
  output logic [31:0] branch_tgt,
  output logic        alu_ne,
  output logic        alu_lt
);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_W3   = 5'b00011;
  localparam logic [4:0] OP_W21  = 5'b10101;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_BLT  = 5'b00110;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_AND = 5'b00010;
  localparam logic [4:0] ALU_OR  = 5'b00011;
  localparam logic [4:0] ALU_SLL = 5'b00100;
  localparam logic [4:0] ALU_SRA = 5'b00101;

  function automatic logic is_writer(input logic [4:0] op);
    return (op == OP_R) || (op == OP_ADDI) || (op == OP_W3) || (op == OP_W21) || (op == OP_LW);
  endfunction

  function automatic logic is_imm(input logic [4:0] op);
    return (op == OP_ADDI) || (op == OP_SW) || (op == OP_LW) || (op == OP_BNE) || (op == OP_BLT);
  endfunction

  logic [31:0] xm_ir_q, xm_ir_d;
  logic [31:0] xm_o_q, xm_o_d;
  logic [31:0] xm_b_q, xm_b_d;
  logic        xm_ovf_q, xm_ovf_d;

  logic [4:0]  dx_op, dx_rd, dx_rs, dx_rt, dx_shamt, dx_aluop, b_src;
  logic [31:0] imm_sext;

  assign dx_op    = dx_ir[31:27];
  assign dx_rd    = dx_ir[26:22];
  assign dx_rs    = dx_ir[21:17];
  assign dx_rt    = dx_ir[16:12];
  assign dx_shamt = dx_ir[11:7];
  assign dx_aluop = dx_ir[6:2];
  assign imm_sext = {{15{dx_ir[16]}}, dx_ir[16:0]};
  // Stores and branches read their second register through the rd field.
  assign b_src    = ((dx_op == OP_SW) || (dx_op == OP_BNE) || (dx_op == OP_BLT)) ? dx_rd : dx_rt;

  logic [31:0] byp_a, byp_b;

`ifdef EXEC_BYPASS_EN
  logic [4:0] xm_op, xm_rd, mw_op, mw_rd;
  logic       xm_fwd_ok, mw_fwd_ok;

  assign xm_op = xm_ir_q[31:27];
  assign xm_rd = xm_ir_q[26:22];
  assign mw_op = mw_ir[31:27];
  assign mw_rd = mw_ir[26:22];
  // A load in X/M has no data yet; the load-use stall belongs upstream.
  assign xm_fwd_ok = is_writer(xm_op) && (xm_op != OP_LW) && (xm_rd != 5'd0);
  assign mw_fwd_ok = is_writer(mw_op) && (mw_rd != 5'd0);

  always_comb begin
    byp_a = dx_a;
    byp_b = dx_b;
    if (xm_fwd_ok && (xm_rd == dx_rs))      byp_a = xm_o_q;
    else if (mw_fwd_ok && (mw_rd == dx_rs)) byp_a = mw_data;
    if (xm_fwd_ok && (xm_rd == b_src))      byp_b = xm_o_q;
    else if (mw_fwd_ok && (mw_rd == b_src)) byp_b = mw_data;
  end

  assign dmem_data = ((xm_op == OP_SW) && mw_fwd_ok && (mw_rd == xm_rd)) ? mw_data : xm_b_q;
`else
  logic unused_mw;
  assign unused_mw = ^{mw_ir, mw_data, b_src};
  assign byp_a     = dx_a;
  assign byp_b     = dx_b;
  assign dmem_data = xm_b_q;
`endif

  logic [31:0] alu_b, alu_res;
  logic [4:0]  alu_op;
  logic        alu_ovf;

  assign alu_b  = is_imm(dx_op) ? imm_sext : byp_b;
  assign alu_op = is_imm(dx_op) ? ALU_ADD : dx_aluop;

  always_comb begin
    alu_res = 32'd0;
    alu_ovf = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_res = byp_a + alu_b;
        alu_ovf = (byp_a[31] == alu_b[31]) && (alu_res[31] != byp_a[31]);
      end
      ALU_SUB: begin
        alu_res = byp_a - alu_b;
        alu_ovf = (byp_a[31] != alu_b[31]) && (alu_res[31] != byp_a[31]);
      end
      ALU_AND: alu_res = byp_a & alu_b;
      ALU_OR:  alu_res = byp_a | alu_b;
      ALU_SLL: alu_res = byp_a << dx_shamt;
      ALU_SRA: alu_res = $signed(byp_a) >>> dx_shamt;
      default: alu_res = 32'd0;
    endcase
  end

  assign branch_tgt = dx_pc + imm_sext;
  assign alu_ne     = (byp_a != byp_b);
  assign alu_lt     = ($signed(byp_a) < $signed(byp_b));

  assign xm_ir_d  = dx_ir;
  assign xm_o_d   = alu_res;
  assign xm_b_d   = byp_b;
  assign xm_ovf_d = alu_ovf;

  // A cleared IR decodes as add r0, so a reset latch never sources a bypass.
  always_ff @(posedge clock) begin
    if (reset) begin
      xm_ir_q  <= 32'd0;
      xm_o_q   <= 32'd0;
      xm_b_q   <= 32'd0;
      xm_ovf_q <= 1'b0;
    end else begin
      xm_ir_q  <= xm_ir_d;
      xm_o_q   <= xm_o_d;
      xm_b_q   <= xm_b_d;
      xm_ovf_q <= xm_ovf_d;
    end
  end

  assign xm_ir  = xm_ir_q;
  assign xm_o   = xm_o_q;
  assign xm_b   = xm_b_q;
  assign xm_ovf = xm_ovf_q;

endmodule

// File: tb/tb_exec_stage_unit.sv
// Directed bench for exec_stage_unit with a reference model and literal spot checks.
module tb_exec_stage_unit;

`ifdef EXEC_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clock, reset;
  logic [31:0] dx_ir, dx_pc, dx_a, dx_b, mw_ir, mw_data;
  logic [31:0] xm_ir, xm_o, xm_b, dmem_data, branch_tgt;
  logic        xm_ovf, alu_ne, alu_lt;

  exec_stage_unit dut (
    .clock(clock), .reset(reset),
    .dx_ir(dx_ir), .dx_pc(dx_pc), .dx_a(dx_a), .dx_b(dx_b),
    .mw_ir(mw_ir), .mw_data(mw_data),
    .xm_ir(xm_ir), .xm_o(xm_o), .xm_b(xm_b), .xm_ovf(xm_ovf),
    .dmem_data(dmem_data), .branch_tgt(branch_tgt),
    .alu_ne(alu_ne), .alu_lt(alu_lt)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // encoders
  function automatic logic [31:0] r_type(input logic [4:0] rd, rs, rt, shamt, aluop);
    return {5'b00000, rd, rs, rt, shamt, aluop, 2'b00};
  endfunction
  function automatic logic [31:0] i_type(input logic [4:0] op, rd, rs, input logic [16:0] imm);
    return {op, rd, rs, imm};
  endfunction

  // reference model: X/M latch contents as the model believes them
  logic [31:0] m_ir, m_o, m_b;
  logic        m_ovf;

  typedef struct {
    logic [31:0] o, b, dmem, tgt;
    logic        ovf, ne, lt;
  } exp_t;

  function automatic bit writes_rd(input logic [31:0] ir);
    logic [4:0] op;
    op = ir[31:27];
    return op inside {5'b00000, 5'b00101, 5'b00011, 5'b10101, 5'b01000};
  endfunction

  // newest producer wins; register 0 is never a producer
  function automatic logic [31:0] operand(input logic [4:0] src, input logic [31:0] regfile_val);
    if (!BYP || src == 5'd0) return regfile_val;
    if (writes_rd(m_ir) && m_ir[31:27] != 5'b01000 && m_ir[26:22] == src) return m_o;
    if (writes_rd(mw_ir) && mw_ir[26:22] == src) return mw_data;
    return regfile_val;
  endfunction

  function automatic exp_t model_eval();
    exp_t e;
    logic [4:0] op, bsrc, sh, fn;
    logic [31:0] a, b, bimm, imm;
    longint sa, sb, s;
    bit immop;
    op    = dx_ir[31:27];
    sh    = dx_ir[11:7];
    fn    = dx_ir[6:2];
    immop = op inside {5'b00101, 5'b00111, 5'b01000, 5'b00010, 5'b00110};
    bsrc  = (op inside {5'b00111, 5'b00010, 5'b00110}) ? dx_ir[26:22] : dx_ir[16:12];
    a     = operand(dx_ir[21:17], dx_a);
    b     = operand(bsrc, dx_b);
    imm   = {{15{dx_ir[16]}}, dx_ir[16:0]};
    bimm  = immop ? imm : b;
    if (immop) fn = 5'b00000;
    sa = longint'($signed(a));
    sb = longint'($signed(bimm));
    e.ovf = 1'b0;
    e.o   = 32'd0;
    case (fn)
      5'd0: begin s = sa + sb; e.o = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd1: begin s = sa - sb; e.o = s[31:0]; e.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      5'd2: e.o = a & bimm;
      5'd3: e.o = a | bimm;
      5'd4: e.o = a * (32'd1 << sh);
      5'd5: begin s = sa >>> sh; e.o = s[31:0]; end
      default: e.o = 32'd0;
    endcase
    e.b   = b;
    e.tgt = dx_pc + imm;
    e.ne  = (a != b);
    e.lt  = (sa < longint'($signed(b)));
    if (BYP && m_ir[31:27] == 5'b00111 && writes_rd(mw_ir) && mw_ir[26:22] != 5'd0
        && mw_ir[26:22] == m_ir[26:22])
      e.dmem = mw_data;
    else
      e.dmem = m_b;
    return e;
  endfunction

  always @(posedge clock) begin
    exp_t e;
    e = model_eval();
    if (reset) begin
      m_ir = 32'd0; m_o = 32'd0; m_b = 32'd0; m_ovf = 1'b0;
    end else begin
      m_ir = dx_ir; m_o = e.o; m_b = e.b; m_ovf = e.ovf;
    end
  end

  // scoreboard compare, every cycle once the latch is defined
  always @(negedge clock) begin
    exp_t e;
    if (chk_en) begin
      e = model_eval();
      chk("xm_ir", xm_ir, m_ir);
      chk("xm_o", xm_o, m_o);
      chk("xm_b", xm_b, m_b);
      chk("xm_ovf", {31'd0, xm_ovf}, {31'd0, m_ovf});
      chk("dmem_data", dmem_data, e.dmem);
      chk("branch_tgt", branch_tgt, e.tgt);
      chk("alu_ne", {31'd0, alu_ne}, {31'd0, e.ne});
      chk("alu_lt", {31'd0, alu_lt}, {31'd0, e.lt});
    end
  end

  // driver tasks
  task automatic set_in(input logic [31:0] ir, pc, a, b, mir, mdata);
    dx_ir = ir; dx_pc = pc; dx_a = a; dx_b = b; mw_ir = mir; mw_data = mdata;
  endtask

  task automatic cyc(input logic [31:0] ir, pc, a, b, mir, mdata);
    set_in(ir, pc, a, b, mir, mdata);
    @(posedge clock);
    #1;
  endtask

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3, SLL = 5'd4, SRA = 5'd5;

  initial begin
    reset = 1'b1;
    set_in(r_type(5'd1, 5'd2, 5'd3, 5'd0, ADD), 32'd40, 32'd11, 32'd22, 32'd0, 32'd0);
    @(posedge clock);
    #1;
    chk_en = 1'b1;
    chk("rst_xm_ir", xm_ir, 32'd0);
    chk("rst_xm_o", xm_o, 32'd0);
    chk("rst_xm_b", xm_b, 32'd0);
    chk("rst_xm_ovf", {31'd0, xm_ovf}, 32'd0);
    reset = 1'b0;

    // ALU corners; rd=1 never matches sources 2/3
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd0, ADD), 32'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0);
    chk("add_ovf_o", xm_o, 32'h80000000);
    chk("add_ovf_flag", {31'd0, xm_ovf}, 32'd1);
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd0, SUB), 32'd0, 32'd5, 32'd7, 32'd0, 32'd0);
    chk("sub_o", xm_o, 32'hFFFFFFFE);
    chk("sub_ovf", {31'd0, xm_ovf}, 32'd0);
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd4, SRA), 32'd0, 32'h80000000, 32'd9, 32'd0, 32'd0);
    chk("sra_o", xm_o, 32'hF8000000);
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd31, SLL), 32'd0, 32'd1, 32'd9, 32'd0, 32'd0);
    chk("sll_o", xm_o, 32'h80000000);
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd0, AND_), 32'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 32'd0, 32'd0);
    chk("and_o", xm_o, 32'h00F0_1234);
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd0, OR_), 32'd0, 32'hF000_0000, 32'h0000_000F, 32'd0, 32'd0);
    chk("or_o", xm_o, 32'hF000_000F);
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd0, 5'd9), 32'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 32'd0);
    chk("undef_aluop_o", xm_o, 32'd0);
    chk("undef_aluop_ovf", {31'd0, xm_ovf}, 32'd0);

    // XM bypass
    cyc(r_type(5'd3, 5'd1, 5'd2, 5'd0, ADD), 32'd0, 32'd4, 32'd5, 32'd0, 32'd0);
    chk("xm_src_o", xm_o, 32'd9);
    cyc(r_type(5'd4, 5'd3, 5'd3, 5'd0, ADD), 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    chk("xm_byp_o", xm_o, BYP ? 32'd18 : 32'd0);

    // lw in XM is not forwarded
    cyc(i_type(5'b01000, 5'd3, 5'd0, 17'h00010), 32'd0, 32'h20, 32'd0, 32'd0, 32'd0);
    chk("lw_addr", xm_o, 32'h30);
    cyc(r_type(5'd4, 5'd3, 5'd3, 5'd0, ADD), 32'd0, 32'd2, 32'd2, 32'd0, 32'd0);
    chk("lw_nofwd_o", xm_o, 32'd4);

    // XM beats MW
    cyc(r_type(5'd5, 5'd1, 5'd2, 5'd0, ADD), 32'd0, 32'd3, 32'd4, 32'd0, 32'd0);
    cyc(r_type(5'd7, 5'd5, 5'd0, 5'd0, ADD), 32'd0, 32'd1, 32'd0,
        r_type(5'd5, 5'd1, 5'd2, 5'd0, ADD), 32'd100);
    chk("prio_xm_o", xm_o, BYP ? 32'd7 : 32'd1);
    cyc(r_type(5'd6, 5'd1, 5'd2, 5'd0, ADD), 32'd0, 32'd3, 32'd4, 32'd0, 32'd0);
    cyc(r_type(5'd7, 5'd5, 5'd0, 5'd0, ADD), 32'd0, 32'd1, 32'd0,
        r_type(5'd5, 5'd1, 5'd2, 5'd0, ADD), 32'd100);
    chk("prio_mw_o", xm_o, BYP ? 32'd100 : 32'd1);

    // rd=0 writers never forward
    cyc(r_type(5'd0, 5'd1, 5'd2, 5'd0, ADD), 32'd0, 32'd3, 32'd4, 32'd0, 32'd0);
    cyc(r_type(5'd7, 5'd0, 5'd0, 5'd0, ADD), 32'd0, 32'd1, 32'd2,
        r_type(5'd0, 5'd1, 5'd2, 5'd0, ADD), 32'd55);
    chk("r0_nofwd_o", xm_o, 32'd3);

    // store data path
    cyc(i_type(5'b00111, 5'd5, 5'd1, 17'd8), 32'd0, 32'h100, 32'h11, 32'd0, 32'd0);
    chk("sw_addr", xm_o, 32'h108);
    chk("sw_xm_b", xm_b, 32'h11);
    set_in(32'd0, 32'd0, 32'd0, 32'd0, r_type(5'd5, 5'd1, 5'd2, 5'd0, ADD), 32'h55);
    #2;
    chk("sw_dmem_mw", dmem_data, BYP ? 32'h55 : 32'h11);
    @(posedge clock);
    #1;
    cyc(i_type(5'b00111, 5'd5, 5'd1, 17'd8), 32'd0, 32'h100, 32'h11, 32'd0, 32'd0);
    set_in(32'd0, 32'd0, 32'd0, 32'd0, r_type(5'd0, 5'd1, 5'd2, 5'd0, ADD), 32'h66);
    #2;
    chk("sw_dmem_r0", dmem_data, 32'h11);
    @(posedge clock);
    #1;

    // branch target and compare flags
    set_in(i_type(5'b00010, 5'd8, 5'd9, 17'h1FFFD), 32'd10, 32'd4, 32'hFFFFFFFF, 32'd0, 32'd0);
    #2;
    chk("br_tgt", branch_tgt, 32'd7);
    chk("br_ne", {31'd0, alu_ne}, 32'd1);
    chk("br_lt", {31'd0, alu_lt}, 32'd0);
    @(posedge clock);
    #1;
    chk("bne_xm_o", xm_o, 32'd1);
    set_in(i_type(5'b00110, 5'd8, 5'd9, 17'h00004), 32'hFFFFFFFE, 32'hFFFFFFF0, 32'd3, 32'd0, 32'd0);
    #2;
    chk("blt_tgt_wrap", branch_tgt, 32'd2);
    chk("blt_lt", {31'd0, alu_lt}, 32'd1);
    @(posedge clock);
    #1;

    // reset mid-stream drops the in-flight instruction
    reset = 1'b1;
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd0, ADD), 32'd0, 32'd5, 32'd6, 32'd0, 32'd0);
    chk("midrst_ir", xm_ir, 32'd0);
    chk("midrst_o", xm_o, 32'd0);
    reset = 1'b0;
    cyc(r_type(5'd1, 5'd2, 5'd3, 5'd0, ADD), 32'd0, 32'd5, 32'd6, 32'd0, 32'd0);
    chk("post_rst_o", xm_o, 32'd11);
    cyc(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    @(negedge clock);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
